// File: rtl/roberto_pkg.sv
// rtl/roberto_pkg.sv - shared constants, FSM state type and decimal split helper for roberto
package roberto_pkg;

   localparam int CLOCKS_PER_BIT = 434;
   localparam int CLOCKS_PER_CM  = 2941;
   localparam int TRIGGER_CYCLES = 500;
   localparam int TIMEOUT_CYCLES = 1_500_000;

   localparam logic [6:0] ASCII_ZERO  = 7'h30;
   localparam logic [6:0] ASCII_COMMA = 7'h2C;
   localparam logic [6:0] ASCII_HASH  = 7'h23;
   localparam logic [9:0] DIST_MAX    = 10'd999;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_TRIGGER,
      ST_MEASURE,
      ST_TRANSMIT,
      ST_DONE
   } state_t;

   // Splits 0..999 into three ASCII digits {hundreds, tens, ones} with a compare chain.
   function automatic logic [20:0] dec3(input logic [9:0] v);
      logic [3:0] h;
      logic [3:0] t;
      logic [9:0] r;
      h = '0;
      t = '0;
      for (int i = 1; i < 10; i++) begin
         if (v >= 10'(i * 100)) h = 4'(i);
      end
      r = v - 10'(h) * 10'd100;
      for (int i = 1; i < 10; i++) begin
         if (r >= 10'(i * 10)) t = 4'(i);
      end
      r = r - 10'(t) * 10'd10;
      return {ASCII_ZERO + 7'(h), ASCII_ZERO + 7'(t), ASCII_ZERO + 7'(r)};
   endfunction

endpackage

// File: rtl/roberto_sonar_channel.sv
// rtl/roberto_sonar_channel.sv - one ultrasonic channel: echo sync, timeout, rounded cm counter
module roberto_sonar_channel
   import roberto_pkg::*;
#(
   parameter int CLOCKS_PER_CM  = roberto_pkg::CLOCKS_PER_CM,
   parameter int TIMEOUT_CYCLES = roberto_pkg::TIMEOUT_CYCLES
)(
   input  logic       clock,
   input  logic       reset,
   input  logic       i_clear,
   input  logic       i_run,
   input  logic       i_echo,
   output logic       o_done,
   output logic [9:0] o_distance
);

   localparam int SW = $clog2(CLOCKS_PER_CM);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   logic [1:0]    r_echo_sync;
   logic          r_counting;
   logic [SW-1:0] r_sub;
   logic [9:0]    r_cm;
   logic [TW-1:0] r_timer;
   logic          r_done;
   logic [9:0]    r_dist;
   logic          w_echo;
   logic          w_wrap;

   assign w_echo = r_echo_sync[1];
   assign w_wrap = (r_sub == SW'(CLOCKS_PER_CM - 1));

   // Sub-counter starts at half a centimetre so the cm count rounds to nearest.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_echo_sync <= '0;
         r_counting  <= 1'b0;
         r_sub       <= '0;
         r_cm        <= '0;
         r_timer     <= '0;
         r_done      <= 1'b0;
         r_dist      <= '0;
      end else begin
         r_echo_sync <= {r_echo_sync[0], i_echo};
         if (i_clear) begin
            r_counting <= 1'b0;
            r_sub      <= SW'(CLOCKS_PER_CM / 2);
            r_cm       <= '0;
            r_timer    <= '0;
            r_done     <= 1'b0;
         end else if (i_run && !r_done) begin
            r_timer <= r_timer + 1'b1;
            if (r_timer == TW'(TIMEOUT_CYCLES - 1)) begin
               r_done <= 1'b1;
               r_dist <= DIST_MAX;
            end else if (w_echo) begin
               r_counting <= 1'b1;
               if (w_wrap) begin
                  r_sub <= '0;
                  if (r_cm != 10'd1000) r_cm <= r_cm + 10'd1;
               end else begin
                  r_sub <= r_sub + 1'b1;
               end
            end else if (r_counting) begin
               r_done <= 1'b1;
               r_dist <= (r_cm > DIST_MAX) ? DIST_MAX : r_cm;
            end
         end
      end
   end

   assign o_done     = r_done;
   assign o_distance = r_dist;

endmodule

// File: rtl/roberto.sv
// rtl/roberto.sv - three-channel sonar ranging controller with 7O1 UART report and terminator receiver
module roberto
   import roberto_pkg::*;
#(
   parameter int CLOCKS_PER_BIT = roberto_pkg::CLOCKS_PER_BIT,
   parameter int CLOCKS_PER_CM  = roberto_pkg::CLOCKS_PER_CM,
   parameter int TRIGGER_CYCLES = roberto_pkg::TRIGGER_CYCLES,
   parameter int TIMEOUT_CYCLES = roberto_pkg::TIMEOUT_CYCLES
)(
   input  logic clock,
   input  logic reset,
   input  logic ligar,
   input  logic echo1,
   input  logic echo2,
   input  logic echo3,
   input  logic RX,
   output logic trigger1,
   output logic trigger2,
   output logic trigger3,
   output logic saida_serial,
   output logic pronto
);

   localparam int TCW = $clog2(TRIGGER_CYCLES);
   localparam int BCW = $clog2(CLOCKS_PER_BIT);

   state_t         r_state;
   state_t         w_state_next;
   logic [TCW-1:0] r_trig_cnt;
   logic           w_trig_last;
   logic           w_trigger;
   logic           w_pronto;
   logic           w_clear;
   logic           w_run;
   logic [2:0]     w_done;
   logic           w_all_done;
   logic [9:0]     w_dist1;
   logic [9:0]     w_dist2;
   logic [9:0]     w_dist3;
   logic [20:0]    w_dec1;
   logic [20:0]    w_dec2;
   logic [20:0]    w_dec3;

   logic [9:0]     r_tx_shift;
   logic [BCW-1:0] r_tx_clk;
   logic [3:0]     r_tx_bit;
   logic [3:0]     r_tx_idx;
   logic [3:0]     w_char_idx;
   logic [6:0]     w_char;
   logic           w_bit_end;
   logic           w_char_end;
   logic           w_tx_load;
   logic           w_tx_last;

   logic [2:0]     r_rx_sync;
   logic           r_rx_busy;
   logic [BCW-1:0] r_rx_cnt;
   logic [3:0]     r_rx_bitn;
   logic [7:0]     r_rx_bits;
   logic [6:0]     r_term;
   logic           w_rx;
   logic           w_rx_fall;

   always_ff @(posedge clock) begin
      if (reset) r_state <= ST_IDLE;
      else       r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE, ST_DONE: if (ligar)       w_state_next = ST_TRIGGER;
         ST_TRIGGER:       if (w_trig_last) w_state_next = ST_MEASURE;
         ST_MEASURE:       if (w_all_done)  w_state_next = ST_TRANSMIT;
         ST_TRANSMIT:      if (w_tx_last)   w_state_next = ST_DONE;
         default:                           w_state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      w_trigger = (r_state == ST_TRIGGER);
      w_pronto  = (r_state == ST_DONE);
      w_clear   = (r_state == ST_TRIGGER);
      w_run     = (r_state == ST_MEASURE);
   end

   assign trigger1 = w_trigger;
   assign trigger2 = w_trigger;
   assign trigger3 = w_trigger;
   assign pronto   = w_pronto;

   always_ff @(posedge clock) begin
      if (reset)                     r_trig_cnt <= '0;
      else if (r_state == ST_TRIGGER) r_trig_cnt <= r_trig_cnt + 1'b1;
      else                           r_trig_cnt <= '0;
   end
   assign w_trig_last = (r_state == ST_TRIGGER) && (r_trig_cnt == TCW'(TRIGGER_CYCLES - 1));

   roberto_sonar_channel #(.CLOCKS_PER_CM(CLOCKS_PER_CM), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_ch1 (
      .clock(clock), .reset(reset), .i_clear(w_clear), .i_run(w_run), .i_echo(echo1),
      .o_done(w_done[0]), .o_distance(w_dist1));
   roberto_sonar_channel #(.CLOCKS_PER_CM(CLOCKS_PER_CM), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_ch2 (
      .clock(clock), .reset(reset), .i_clear(w_clear), .i_run(w_run), .i_echo(echo2),
      .o_done(w_done[1]), .o_distance(w_dist2));
   roberto_sonar_channel #(.CLOCKS_PER_CM(CLOCKS_PER_CM), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_ch3 (
      .clock(clock), .reset(reset), .i_clear(w_clear), .i_run(w_run), .i_echo(echo3),
      .o_done(w_done[2]), .o_distance(w_dist3));

   assign w_all_done = &w_done;
   assign w_dec1     = dec3(w_dist1);
   assign w_dec2     = dec3(w_dist2);
   assign w_dec3     = dec3(w_dist3);

   // Index of the character loaded at the next load strobe; the terminator is read live here.
   assign w_char_idx = (r_state == ST_MEASURE) ? 4'd0 : r_tx_idx + 4'd1;

   always_comb begin
      w_char = ASCII_COMMA;
      case (w_char_idx)
         4'd0:    w_char = w_dec1[20:14];
         4'd1:    w_char = w_dec1[13:7];
         4'd2:    w_char = w_dec1[6:0];
         4'd4:    w_char = w_dec2[20:14];
         4'd5:    w_char = w_dec2[13:7];
         4'd6:    w_char = w_dec2[6:0];
         4'd8:    w_char = w_dec3[20:14];
         4'd9:    w_char = w_dec3[13:7];
         4'd10:   w_char = w_dec3[6:0];
         4'd11:   w_char = r_term;
         default: w_char = ASCII_COMMA;
      endcase
   end

   assign w_bit_end  = (r_tx_clk == BCW'(CLOCKS_PER_BIT - 1));
   assign w_char_end = (r_state == ST_TRANSMIT) && w_bit_end && (r_tx_bit == 4'd9);
   assign w_tx_load  = ((r_state == ST_MEASURE) && w_all_done) || (w_char_end && (r_tx_idx != 4'd11));
   assign w_tx_last  = w_char_end && (r_tx_idx == 4'd11);

   // Shift register bit 0 drives the line; ones fill in behind so it rests idle-high.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_tx_shift <= '1;
         r_tx_clk   <= '0;
         r_tx_bit   <= '0;
         r_tx_idx   <= '0;
      end else if (w_tx_load) begin
         r_tx_shift <= {1'b1, ~^w_char, w_char, 1'b0};
         r_tx_clk   <= '0;
         r_tx_bit   <= '0;
         r_tx_idx   <= w_char_idx;
      end else if (r_state == ST_TRANSMIT) begin
         if (w_bit_end) begin
            r_tx_clk   <= '0;
            r_tx_bit   <= r_tx_bit + 4'd1;
            r_tx_shift <= {1'b1, r_tx_shift[9:1]};
         end else begin
            r_tx_clk <= r_tx_clk + 1'b1;
         end
      end
   end
   assign saida_serial = r_tx_shift[0];

   assign w_rx      = r_rx_sync[1];
   assign w_rx_fall = r_rx_sync[2] & ~r_rx_sync[1];

   always_ff @(posedge clock) begin
      if (reset) begin
         r_rx_sync <= 3'b111;
         r_rx_busy <= 1'b0;
         r_rx_cnt  <= '0;
         r_rx_bitn <= '0;
         r_rx_bits <= '0;
         r_term    <= ASCII_HASH;
      end else begin
         r_rx_sync <= {r_rx_sync[1:0], RX};
         if (!r_rx_busy) begin
            if (w_rx_fall) begin
               r_rx_busy <= 1'b1;
               r_rx_cnt  <= '0;
               r_rx_bitn <= '0;
            end
         end else if (r_rx_bitn == 4'd0) begin
            if (r_rx_cnt == BCW'(CLOCKS_PER_BIT / 2 - 1)) begin
               r_rx_cnt <= '0;
               if (!w_rx) r_rx_bitn <= 4'd1;
               else       r_rx_busy <= 1'b0;
            end else begin
               r_rx_cnt <= r_rx_cnt + 1'b1;
            end
         end else if (r_rx_cnt == BCW'(CLOCKS_PER_BIT - 1)) begin
            r_rx_cnt <= '0;
            if (r_rx_bitn == 4'd9) begin
               r_rx_busy <= 1'b0;
               if (w_rx && (r_rx_bits[7] == ~^r_rx_bits[6:0])) r_term <= r_rx_bits[6:0];
            end else begin
               r_rx_bits <= {w_rx, r_rx_bits[7:1]};
               r_rx_bitn <= r_rx_bitn + 4'd1;
            end
         end else begin
            r_rx_cnt <= r_rx_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_roberto.sv
// tb/tb_roberto.sv - directed self-checking bench for roberto with shortened timing parameters
module tb_roberto;

   localparam int CPB  = 8;
   localparam int CPC  = 20;
   localparam int TRIG = 12;
   localparam int TMO  = 4000;

   logic clock = 1'b0;
   logic reset, ligar, echo1, echo2, echo3, RX;
   logic trigger1, trigger2, trigger3, saida_serial, pronto;
   int   checks = 0;
   int   errors = 0;

   roberto #(
      .CLOCKS_PER_BIT(CPB), .CLOCKS_PER_CM(CPC), .TRIGGER_CYCLES(TRIG), .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clock(clock), .reset(reset), .ligar(ligar),
      .echo1(echo1), .echo2(echo2), .echo3(echo3), .RX(RX),
      .trigger1(trigger1), .trigger2(trigger2), .trigger3(trigger3),
      .saida_serial(saida_serial), .pronto(pronto)
   );

   always #5 clock = ~clock;

   task automatic tick(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic get_frame(output logic [95:0] frame, output int bad);
      logic [7:0] ch;
      int t;
      bad   = 0;
      frame = '0;
      for (int c = 0; c < 12; c++) begin
         t = 0;
         while (saida_serial !== 1'b0 && t < 8000) begin
            @(negedge clock);
            t++;
         end
         if (t >= 8000) bad += 100;
         if (c > 0 && t != CPB / 2) bad++;
         tick(CPB / 2);
         if (saida_serial !== 1'b0) bad++;
         ch = '0;
         for (int b = 0; b < 7; b++) begin
            tick(CPB);
            ch[b] = saida_serial;
         end
         tick(CPB);
         if (saida_serial !== ~^ch[6:0]) bad++;
         tick(CPB);
         if (saida_serial !== 1'b1) bad++;
         frame = {frame[87:0], ch};
      end
   endtask

   task automatic send_rx(input logic [6:0] d, input bit flip_par, input bit bad_stop);
      RX = 1'b0;
      tick(CPB);
      for (int b = 0; b < 7; b++) begin
         RX = d[b];
         tick(CPB);
      end
      RX = (~^d) ^ flip_par;
      tick(CPB);
      RX = ~bad_stop;
      tick(CPB);
      RX = 1'b1;
      tick(2 * CPB);
   endtask

   task automatic run_cycle(input string tag, input int n1, input int n2, input int n3,
                            input logic [95:0] exp, input bit hold);
      int t, w, mx, bad;
      logic [95:0] got;
      ligar = 1'b1;
      t = 0;
      while (trigger1 !== 1'b1 && t < 100) begin
         @(negedge clock);
         t++;
      end
      chk({tag, " triggers_high"}, {93'b0, trigger1, trigger2, trigger3}, 96'h7);
      chk({tag, " pronto_cleared"}, {95'b0, pronto}, 96'h0);
      if (!hold) ligar = 1'b0;
      w = 0;
      while (trigger1 === 1'b1 && w < 1000) begin
         @(negedge clock);
         w++;
      end
      chk({tag, " trigger_width"}, 96'(w), 96'(TRIG));
      mx = n1;
      if (n2 > mx) mx = n2;
      if (n3 > mx) mx = n3;
      for (int k = 0; k < mx; k++) begin
         echo1 = (k < n1);
         echo2 = (k < n2);
         echo3 = (k < n3);
         @(negedge clock);
      end
      echo1 = 1'b0;
      echo2 = 1'b0;
      echo3 = 1'b0;
      get_frame(got, bad);
      chk({tag, " frame"}, got, exp);
      chk({tag, " uart_format"}, 96'(bad), 96'd0);
      tick(3);
      chk({tag, " pronto_in_stop"}, {95'b0, pronto}, 96'h0);
      tick(1);
      chk({tag, " pronto_set"}, {95'b0, pronto}, 96'h1);
   endtask

   initial begin
      int t;
      reset = 1'b1;
      ligar = 1'b0;
      echo1 = 1'b0;
      echo2 = 1'b0;
      echo3 = 1'b0;
      RX    = 1'b1;
      tick(3);
      chk("reset_outputs", {91'b0, trigger1, trigger2, trigger3, saida_serial, pronto}, 96'h2);
      reset = 1'b0;
      tick(2);

      run_cycle("exact100", 2000, 2000, 2000, "100,100,100#", 1'b0);
      tick(5);
      run_cycle("round_down100", 2005, 2005, 2005, "100,100,100#", 1'b0);
      tick(5);
      run_cycle("round_edge", 1489, 1490, 2005, "074,075,100#", 1'b0);
      tick(5);

      send_rx(7'h2A, 1'b0, 1'b0);
      send_rx(7'h4C, 1'b0, 1'b0);
      send_rx(7'h70, 1'b0, 1'b0);
      run_cycle("rx_term_p", 2000, 2000, 2000, "100,100,100p", 1'b0);
      tick(5);

      send_rx(7'h41, 1'b0, 1'b0);
      send_rx(7'h42, 1'b1, 1'b0);
      send_rx(7'h43, 1'b0, 1'b1);
      run_cycle("rx_bad_frames", 1489, 1489, 1489, "074,074,074A", 1'b0);
      tick(5);

      run_cycle("timeout_ch2", 2000, 0, 2000, "100,999,100A", 1'b0);
      tick(5);

      run_cycle("held_first", 2000, 2000, 2000, "100,100,100A", 1'b1);
      run_cycle("held_second", 1490, 1490, 1490, "075,075,075A", 1'b0);
      tick(5);

      ligar = 1'b1;
      t = 0;
      while (trigger1 !== 1'b1 && t < 100) begin
         @(negedge clock);
         t++;
      end
      ligar = 1'b0;
      t = 0;
      while (trigger1 === 1'b1 && t < 1000) begin
         @(negedge clock);
         t++;
      end
      for (int k = 0; k < 2000; k++) begin
         echo1 = 1'b1;
         echo2 = 1'b1;
         echo3 = 1'b1;
         @(negedge clock);
      end
      echo1 = 1'b0;
      echo2 = 1'b0;
      echo3 = 1'b0;
      t = 0;
      while (saida_serial !== 1'b0 && t < 8000) begin
         @(negedge clock);
         t++;
      end
      chk("tx_started", {95'b0, saida_serial}, 96'h0);
      tick(1);
      reset = 1'b1;
      tick(1);
      chk("reset_mid_tx", {91'b0, trigger1, trigger2, trigger3, saida_serial, pronto}, 96'h2);
      reset = 1'b0;
      tick(50);
      chk("idle_after_reset", {94'b0, saida_serial, pronto}, 96'h2);
      run_cycle("after_reset", 2000, 2000, 2000, "100,100,100#", 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
